clock_divider_multi: RTL and testbench
======================================

// Module: clock_divider_multi
// PURPOSE
//   Multi-channel programmable clock divider, the successor to the fixed single-channel divider.
//   Each of CHANNELS independent counters divides clk_in by a divisor that can be changed at run time.
//   Each channel produces a 50%-duty toggled clock and a one-cycle tick.
//   Feeds display multiplexing, debounce sampling and blink timing from one block.
// PARAMETERS
//   CHANNELS       4          number of independent divider channels (1..8)
//   WIDTH          26         counter/limit width in bits
//   SEL_W          2          width of wr_sel; 2**SEL_W >= CHANNELS
//   DEFAULT_LIMIT  25000000   limit loaded into every channel at reset
// PORTS
//   clk_in    in   1                 system clock
//   rst_n     in   1                 asynchronous reset, active low
//   en        in   CHANNELS          per-channel count enable
//   wr_en     in   1                 limit write strobe (one cycle)
//   wr_sel    in   SEL_W             channel addressed by the write
//   wr_limit  in   WIDTH             new limit value
//   wr_now    in   1                 1 = apply immediately and restart; 0 = defer to next wrap
//   clk_out   out  CHANNELS          divided clocks, period 2*(limit+1) clk_in cycles
//   tick_out  out  CHANNELS          one-cycle pulse per wrap, period limit+1
//   pending   out  CHANNELS          deferred limit waiting to be applied
// BEHAVIOUR
//   - Reset (rst_n=0, async):
//       count=0, limit=DEFAULT_LIMIT, shadow=0.
//       clk_out=0, tick_out=0, pending=0 on all channels.
//   - Clocked on posedge clk_in. All outputs are registered.
//   - Channel i with en[i]=1:
//       if count==limit: count<=0, clk_out[i]<=~clk_out[i], tick_out[i]<=1.
//       else: count<=count+1, tick_out[i]<=0.
//   - tick_out[i] is high for exactly the one cycle after the wrap edge, coincident with the new clk_out level.
//   - Channel i with en[i]=0: count and clk_out[i] hold, tick_out[i]<=0. Counting resumes from the held count.
//   - Write accepted when wr_en=1 and wr_sel<CHANNELS. If wr_sel>=CHANNELS the write is ignored, with no state change.
//   - Immediate write (wr_now=1):
//       limit<=wr_limit, count<=0, clk_out<=0, tick_out<=0, pending<=0.
//       Applies even if en=0 and overrides a wrap in the same cycle.
//   - Deferred write (wr_now=0): shadow<=wr_limit, pending<=1.
//       At the next wrap, limit<=shadow and pending<=0.
//       A second deferred write before that wrap overwrites shadow; only the last value is applied.
//   - Deferred write in the same cycle as a wrap:
//       that wrap uses the previous shadow if one is pending, otherwise the old limit.
//       The new value stays pending and is applied at the following wrap.
//   - A pending limit on a disabled channel is applied at the first wrap after it is re-enabled.
//   - limit=0: wrap every enabled cycle, so clk_out = clk_in/2 and tick_out stays high.
//   - count never exceeds limit, because limits change only at wrap or with count cleared.
//       The comparison is equality; no overflow handling is needed.
//   - Arithmetic is unsigned WIDTH bits and count+1 never wraps.
//   - Channels are fully independent; simultaneous wraps on several channels are allowed.
// TESTING (bench params CHANNELS=4, WIDTH=8, SEL_W=3, DEFAULT_LIMIT=4)
//   1. Release reset, en=4'b1111
//      -> every tick_out pulses every 5 cycles; clk_out period 10, high 5; all channels aligned.
//   2. Deferred write ch1 limit=1 at count=2
//      -> pending[1]=1 until the current period ends (2 more cycles); then tick every 2 cycles, pending[1]=0.
//   3. Immediate write ch2 limit=7 with clk_out[2]=1
//      -> next cycle clk_out[2]=0, count=0; first tick 8 cycles later.
//   4. en[0]=0 for 13 cycles at count=3
//      -> clk_out[0] frozen, no tick; after re-enable, the wrap comes 2 cycles later.
//   5. Write wr_sel=5 limit=0
//      -> no channel changes. Write ch3 limit=0 now -> tick_out[3] high continuously, clk_out[3] toggles every cycle.
//   6. Deassert rst_n mid-count with pending[1]=1
//      -> outputs 0 immediately without a clock; after release, limits=4 and pending=0.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: per-channel wrap counter with a runtime limit,
// 50%-duty toggled output, one-cycle wrap tick, and immediate or wrap-deferred limit updates.
module clock_divider_multi #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned WIDTH         = 26,
    parameter int unsigned SEL_W         = 2,
    parameter int unsigned DEFAULT_LIMIT = 25000000
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic [WIDTH-1:0]    wr_limit,
    input  logic                wr_now,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick_out,
    output logic [CHANNELS-1:0] pending
);

    logic [WIDTH-1:0]    count_q  [CHANNELS];
    logic [WIDTH-1:0]    count_d  [CHANNELS];
    logic [WIDTH-1:0]    limit_q  [CHANNELS];
    logic [WIDTH-1:0]    limit_d  [CHANNELS];
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [CHANNELS-1:0] clk_q, clk_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] pend_q, pend_d;

    always_comb begin
        clk_d  = clk_q;
        tick_d = '0;
        pend_d = pend_q;
        for (int i = 0; i < CHANNELS; i++) begin
            count_d[i]  = count_q[i];
            limit_d[i]  = limit_q[i];
            shadow_d[i] = shadow_q[i];

            if (en[i]) begin
                if (count_q[i] == limit_q[i]) begin
                    count_d[i] = '0;
                    clk_d[i]   = ~clk_q[i];
                    tick_d[i]  = 1'b1;
                    if (pend_q[i]) begin
                        limit_d[i] = shadow_q[i];
                        pend_d[i]  = 1'b0;
                    end
                end else begin
                    count_d[i] = count_q[i] + WIDTH'(1);
                end
            end

            // Writes are evaluated after the wrap so they take priority over it; a deferred
            // write landing on a wrap stays pending for the following wrap.
            if (wr_en && (32'(wr_sel) == i)) begin
                if (wr_now) begin
                    limit_d[i] = wr_limit;
                    count_d[i] = '0;
                    clk_d[i]   = 1'b0;
                    tick_d[i]  = 1'b0;
                    pend_d[i]  = 1'b0;
                end else begin
                    shadow_d[i] = wr_limit;
                    pend_d[i]   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]  <= '0;
                limit_q[i]  <= WIDTH'(DEFAULT_LIMIT);
                shadow_q[i] <= '0;
            end
            clk_q  <= '0;
            tick_q <= '0;
            pend_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]  <= count_d[i];
                limit_q[i]  <= limit_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            clk_q  <= clk_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

    assign clk_out  = clk_q;
    assign tick_out = tick_q;
    assign pending  = pend_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed scenarios plus random traffic, every cycle compared
// against a period/wrap-count model of each channel.
module tb_clock_divider_multi;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned SW = 3;
    localparam int unsigned DL = 4;

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic [CH-1:0] en;
    logic          wr_en;
    logic [SW-1:0] wr_sel;
    logic [W-1:0]  wr_limit;
    logic          wr_now;
    logic [CH-1:0] clk_out, tick_out, pending;

    clock_divider_multi #(
        .CHANNELS      (CH),
        .WIDTH         (W),
        .SEL_W         (SW),
        .DEFAULT_LIMIT (DL)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_limit (wr_limit),
        .wr_now   (wr_now),
        .clk_out  (clk_out),
        .tick_out (tick_out),
        .pending  (pending)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycles elapsed in the current period, wraps since restart (clk_out is its parity).
    int m_elapsed [CH];
    int m_lim     [CH];
    int m_sh      [CH];
    int m_wraps   [CH];
    bit m_pend    [CH];
    bit m_tick    [CH];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_elapsed[c] = 0; m_lim[c] = DL; m_sh[c] = 0;
            m_wraps[c] = 0; m_pend[c] = 0; m_tick[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            m_tick[c] = 0;
            if (en[c]) begin
                if (m_elapsed[c] >= m_lim[c]) begin
                    m_elapsed[c] = 0;
                    m_wraps[c]++;
                    m_tick[c] = 1;
                    if (m_pend[c]) begin
                        m_lim[c] = m_sh[c];
                        m_pend[c] = 0;
                    end
                end else begin
                    m_elapsed[c]++;
                end
            end
            if (wr_en && int'(wr_sel) == c) begin
                if (wr_now) begin
                    m_lim[c] = int'(wr_limit); m_elapsed[c] = 0; m_wraps[c] = 0;
                    m_tick[c] = 0; m_pend[c] = 0;
                end else begin
                    m_sh[c] = int'(wr_limit); m_pend[c] = 1;
                end
            end
        end
    endtask

    function automatic logic [3*CH-1:0] exp_vec();
        logic [CH-1:0] c_v, t_v, p_v;
        for (int c = 0; c < CH; c++) begin
            c_v[c] = (m_wraps[c] % 2) == 1;
            t_v[c] = m_tick[c];
            p_v[c] = m_pend[c];
        end
        return {c_v, t_v, p_v};
    endfunction

    // Advance one clock; DUT and model both see the inputs held across the edge.
    task automatic cyc();
        @(posedge clk_in);
        if (rst_n) model_step();
        else model_reset();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = '0; wr_en = 0; wr_sel = '0; wr_limit = '0; wr_now = 0;
        model_reset();
        #12;
        n_checks++;
        if ({clk_out, tick_out, pending} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", {clk_out, tick_out, pending}, 12'h000);
        end
        @(negedge clk_in);
        en = 4'b1111;
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        int nt = 0, nh = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            n_checks++;
            if ({clk_out, tick_out, pending} !== exp_vec()) begin
                n_fail++;
                $display("FAIL free_run cyc %0d: got %h want %h", k, {clk_out, tick_out, pending}, exp_vec());
            end
            if (tick_out === 4'hf) nt++;
            if (clk_out === 4'hf) nh++;
        end
        n_checks++;
        if (nt != 4) begin
            n_fail++;
            $display("FAIL free_run_ticks: got %0d aligned ticks want 4", nt);
        end
        n_checks++;
        if (nh != 10) begin
            n_fail++;
            $display("FAIL free_run_high: got %0d aligned high cycles want 10", nh);
        end
    endtask

    task automatic test_deferred();
        int n;
        for (int k = 0; k < 10 && m_elapsed[1] != 2; k++) cyc();
        wr_en = 1; wr_sel = 3'd1; wr_limit = 8'd1; wr_now = 0;
        cyc();
        wr_en = 0;
        n_checks++;
        if (pending[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL deferred_pending: got %b want 1", pending[1]);
        end
        n = 0;
        do begin
            cyc(); n++;
            n_checks++;
            if ({clk_out, tick_out, pending} !== exp_vec()) begin
                n_fail++;
                $display("FAIL deferred cyc %0d: got %h want %h", n, {clk_out, tick_out, pending}, exp_vec());
            end
        end while (pending[1] !== 1'b0 && n < 20);
        n_checks++;
        if (n != 2) begin
            n_fail++;
            $display("FAIL deferred_apply_delay: got %0d cycles want 2", n);
        end
        n = 0;
        do begin cyc(); n++; end while (tick_out[1] !== 1'b1 && n < 20);
        n_checks++;
        if (n != 2) begin
            n_fail++;
            $display("FAIL deferred_new_period: got %0d cycles want 2", n);
        end
    endtask

    task automatic test_immediate();
        int n;
        for (int k = 0; k < 20 && (m_wraps[2] % 2) != 1; k++) cyc();
        wr_en = 1; wr_sel = 3'd2; wr_limit = 8'd7; wr_now = 1;
        cyc();
        wr_en = 0; wr_now = 0;
        n_checks++;
        if (clk_out[2] !== 1'b0 || tick_out[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL immediate_restart: got clk %b tick %b want 0 0", clk_out[2], tick_out[2]);
        end
        n = 0;
        do begin
            cyc(); n++;
            n_checks++;
            if ({clk_out, tick_out, pending} !== exp_vec()) begin
                n_fail++;
                $display("FAIL immediate cyc %0d: got %h want %h", n, {clk_out, tick_out, pending}, exp_vec());
            end
        end while (tick_out[2] !== 1'b1 && n < 30);
        n_checks++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL immediate_first_tick: got %0d cycles want 8", n);
        end
    endtask

    task automatic test_enable_hold();
        int n;
        logic held;
        for (int k = 0; k < 10 && m_elapsed[0] != 3; k++) cyc();
        held = (m_wraps[0] % 2) == 1;
        en[0] = 1'b0;
        for (int k = 0; k < 13; k++) begin
            cyc();
            n_checks++;
            if (clk_out[0] !== held || tick_out[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_hold cyc %0d: got clk %b tick %b want %b 0", k, clk_out[0], tick_out[0], held);
            end
        end
        en[0] = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (tick_out[0] !== 1'b1 && n < 20);
        n_checks++;
        if (n != 2) begin
            n_fail++;
            $display("FAIL enable_resume: got %0d cycles want 2", n);
        end
    endtask

    task automatic test_limit_zero();
        logic prev;
        wr_en = 1; wr_sel = 3'd5; wr_limit = 8'd0; wr_now = 1;
        cyc();
        n_checks++;
        if ({clk_out, tick_out, pending} !== exp_vec()) begin
            n_fail++;
            $display("FAIL bad_sel_ignored: got %h want %h", {clk_out, tick_out, pending}, exp_vec());
        end
        wr_sel = 3'd3;
        cyc();
        wr_en = 0; wr_now = 0;
        prev = clk_out[3];
        for (int k = 0; k < 6; k++) begin
            cyc();
            n_checks++;
            if (tick_out[3] !== 1'b1 || clk_out[3] !== ~prev) begin
                n_fail++;
                $display("FAIL limit_zero cyc %0d: got clk %b tick %b want %b 1", k, clk_out[3], tick_out[3], ~prev);
            end
            n_checks++;
            if ({clk_out, tick_out, pending} !== exp_vec()) begin
                n_fail++;
                $display("FAIL limit_zero_all cyc %0d: got %h want %h", k, {clk_out, tick_out, pending}, exp_vec());
            end
            prev = clk_out[3];
        end
    endtask

    task automatic test_async_reset();
        int n;
        wr_en = 1; wr_sel = 3'd1; wr_limit = 8'd3; wr_now = 0;
        cyc();
        wr_en = 0;
        n_checks++;
        if (pending[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_pending: got %b want 1", pending[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({clk_out, tick_out, pending} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", {clk_out, tick_out, pending}, 12'h000);
        end
        cyc(); cyc();
        rst_n = 1'b1;
        n = 0;
        do begin
            cyc(); n++;
            n_checks++;
            if ({clk_out, tick_out, pending} !== exp_vec()) begin
                n_fail++;
                $display("FAIL post_reset cyc %0d: got %h want %h", n, {clk_out, tick_out, pending}, exp_vec());
            end
        end while (tick_out !== 4'hf && n < 20);
        n_checks++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL post_reset_period: got %0d cycles want 5", n);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en       = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hf;
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_sel   = 3'($urandom_range(0, 7));
            wr_limit = 8'($urandom_range(0, 6));
            wr_now   = $urandom_range(0, 1) == 1;
            cyc();
            n_checks++;
            if ({clk_out, tick_out, pending} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", k, {clk_out, tick_out, pending}, exp_vec());
            end
        end
        wr_en = 0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_deferred();
        test_immediate();
        test_enable_hold();
        test_limit_zero();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
